// File: rtl/atomic_counter_reader.sv
// rtl/atomic_counter_reader.sv - host-side atomic 64-bit counter reader (low word atomic, then latched high word)
// Optional wait-state timeout: compile with ATOMIC_READER_TIMEOUT_EN.
module atomic_counter_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_start_i,
  output logic        rd_busy_o,
  output logic        rd_done_o,
  output logic [63:0] rd_data_o,
  output logic        rd_err_o,
  output logic        req_o,
  output logic        atomic_o,
  input  logic        ack_i,
  input  logic [31:0] count_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [63:0] data_q, data_d;
  logic        req_q, req_d;
  logic        atomic_q, atomic_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        timeout_hit;

`ifdef ATOMIC_READER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_q, tmo_d;

  // Watchdog: starts from zero on entry to a wait state, counts ack-less wait cycles
  always_comb begin
    tmo_d       = 8'd0;
    timeout_hit = 1'b0;
    if ((state_q == WAIT_LO || state_q == WAIT_HI) && !ack_i) begin
      tmo_d       = tmo_q + 8'd1;
      timeout_hit = (tmo_d == TMO_LIMIT);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequencer: next state plus next values of the registered outputs and capture words
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    data_d   = data_q;
    req_d    = 1'b0;
    atomic_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start_i) begin
          state_d  = REQ_LO;
          req_d    = 1'b1;
          atomic_d = 1'b1;
        end
      end
      REQ_LO: state_d = WAIT_LO;
      WAIT_LO: begin
        // An ack arriving in the expiry cycle still completes the phase normally
        if (ack_i) begin
          lo_d    = count_i;
          state_d = REQ_HI;
          req_d   = 1'b1;
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          data_d  = 64'h0;
        end
      end
      REQ_HI: state_d = WAIT_HI;
      WAIT_HI: begin
        if (ack_i) begin
          hi_d    = count_i;
          state_d = DONE;
          done_d  = 1'b1;
          data_d  = {count_i, lo_q};
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          data_d  = 64'h0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lo_q     <= 32'h0;
      hi_q     <= 32'h0;
      data_q   <= 64'h0;
      req_q    <= 1'b0;
      atomic_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      req_q    <= req_d;
      atomic_q <= atomic_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rd_busy_o = (state_q != IDLE) && (state_q != DONE);
  assign rd_done_o = done_q;
  assign rd_data_o = data_q;
  assign rd_err_o  = err_q;
  assign req_o     = req_q;
  assign atomic_o  = atomic_q;

endmodule

// File: doc/atomic_counter_reader.md
# atomic_counter_reader

Initiator side of the atomic counter read interface. Converts a single host read command into the two-request atomic sequence on the counter port: an atomic request returning the low word, then a plain request returning the latched high word. Reassembles the 64-bit snapshot and presents it to the host with a done pulse. Sits between a host and the atomic counter responder, on the same clock.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles to wait for `ack_i` before aborting; legal range 2..255; used only when the timeout feature is compiled in.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_start_i`  in  1  host read command; sampled only in IDLE.
- `rd_busy_o`  out  1  high from the cycle after start is accepted until the cycle `rd_done_o` is high.
- `rd_done_o`  out  1  one-cycle pulse; `rd_data_o` and `rd_err_o` are valid in this cycle.
- `rd_data_o`  out  64  assembled snapshot `{hi, lo}`; holds its value until the next `rd_done_o`.
- `rd_err_o`  out  1  high only together with `rd_done_o` when a timeout aborted the read.
- `req_o`  out  1  request to the responder; one-cycle pulse per phase.
- `atomic_o`  out  1  high with `req_o` for the low-word phase, low for the high-word phase.
- `ack_i`  in  1  responder acknowledge; `count_i` is valid in the same cycle.
- `count_i`  in  32  responder data.

## Operation
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE.
- IDLE:
  - `rd_start_i`=1 -> REQ_LO.
  - `ack_i` is ignored.
- REQ_LO:
  - `req_o`=1 and `atomic_o`=1 for exactly one cycle.
  - Then -> WAIT_LO.
- WAIT_LO:
  - On `ack_i`=1, capture `count_i` into lo[31:0], then -> REQ_HI.
- REQ_HI:
  - `req_o`=1 and `atomic_o`=0 for one cycle.
  - Then -> WAIT_HI.
- WAIT_HI:
  - On `ack_i`=1, capture `count_i` into hi[31:0], then -> DONE.
- DONE:
  - `rd_done_o`=1.
  - `rd_data_o` <= `{hi, lo}`, `rd_err_o`=0.
  - -> IDLE.
- `ack_i` in REQ_LO, REQ_HI, DONE or IDLE is spurious. It is ignored, with no capture and no state change.
- `rd_start_i` while busy is ignored; nothing is queued.
- `req_o`, `atomic_o`, `rd_done_o` and `rd_err_o` are registered outputs.
- `rd_busy_o` = (state != IDLE) && (state != DONE) is allowed combinational, or registered equivalent.
- lo and hi are separate 32-bit capture registers. `rd_data_o` updates only in DONE, so a partial read never leaks to the host.

## Timing
- Reset values: all outputs 0, including `rd_data_o` = 64'h0. State is IDLE, the timeout counter is 0, lo and hi are 0.
- Start sampled at edge E0. Against a one-cycle-latency responder:
  - `req_o`/`atomic_o`=1 in cycle 1.
  - `ack_i` with the low word in cycle 2.
  - `req_o`=1, `atomic_o`=0 in cycle 3.
  - `ack_i` with the high word in cycle 4.
  - `rd_done_o` in cycle 5.
- Nominal latency from start to done is 5 cycles. The next start is accepted in cycle 6.
- The high request always issues at least one cycle after the low ack. The responder latches the high word on the edge that ends the low-ack cycle.
- Reset asserted mid-operation:
  - All state clears immediately and `req_o` drops asynchronously.
  - No `rd_done_o` is produced.
  - The host must reissue the read.

## Configuration
- Macro `ATOMIC_READER_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to WAIT_LO/WAIT_HI and increments each cycle in those states without `ack_i`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM -> DONE with `rd_err_o`=1 and `rd_data_o` = 64'h0.
  - An ack in the same cycle as expiry wins; no error.
- Not defined:
  - The wait states hold indefinitely.
  - `rd_err_o` is tied to 0 and the counter logic is absent.

## Test plan
- Reset with `reset_n`=0 -> all outputs 0, `rd_data_o`=64'h0. Release, idle 10 cycles -> `req_o` never asserts.
- Responder model holding count 64'h0000_0001_FFFF_FFFE with trig stopped, start pulse:
  - `req_o`/`atomic_o` in cycle 1, `req_o` alone in cycle 3.
  - `rd_done_o` in cycle 5 with `rd_data_o`=64'h0000_0001_FFFF_FFFE, `rd_err_o`=0.
- Counter incrementing every cycle across the 32-bit wrap from 64'h0000_0000_FFFF_FFFF. Read -> hi equals the high word at the atomic sample; the result is never 64'h0000_0000_0000_0000 or 64'h0000_0001_FFFF_FFFF torn.
- `rd_start_i` held high for 20 cycles -> exactly 3 reads complete, done in cycles 5, 11 and 17. Spurious `ack_i` in IDLE and REQ states -> no capture.
- With `ATOMIC_READER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, responder never acks -> `rd_done_o` with `rd_err_o`=1 and `rd_data_o`=0, 5 cycles after the low request. Without the macro -> `rd_busy_o` stays 1.
- `reset_n` pulsed low during WAIT_HI -> `req_o`=0 and `rd_busy_o`=0 at once, no done. The next read returns correct data.
